// File: rtl/fifo_serializer128.sv
// fifo_serializer128: splits 128-bit FIFO messages into four 32-bit beats, LSW first
module fifo_serializer128 (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] in_first,
  input  logic         in_first__RDY,
  input  logic         in_deq__RDY,
  output logic         in_deq__ENA,
  output logic [31:0]  out_enq_v,
  input  logic         out_enq__RDY,
  output logic         out_enq__ENA
`ifdef SERIALIZER_LAST_EN
  ,
  output logic         out_enq_last
`endif
);
  logic         busy_q, busy_d;
  logic [1:0]   beat_q, beat_d;
  logic [127:0] buf_q, buf_d;
  logic         load_ok, last_beat;
  always_comb begin
    load_ok = in_first__RDY & in_deq__RDY;
    out_enq__ENA = busy_q & out_enq__RDY;
    last_beat = out_enq__ENA & (beat_q == 2'd3);
    in_deq__ENA = !RST & load_ok & (!busy_q | last_beat);
    out_enq_v = buf_q[{beat_q, 5'd0} +: 32];
    busy_d = in_deq__ENA ? 1'b1 : last_beat ? 1'b0 : busy_q;
    beat_d = in_deq__ENA ? 2'd0 : out_enq__ENA ? beat_q + 2'd1 : beat_q;
    buf_d = in_deq__ENA ? in_first : buf_q;
  end
`ifdef SERIALIZER_LAST_EN
  assign out_enq_last = busy_q & (beat_q == 2'd3);
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= 1'b0;
      beat_q <= 2'd0;
      buf_q  <= '0;
    end else begin
      busy_q <= busy_d;
      beat_q <= beat_d;
      buf_q  <= buf_d;
    end
  end
endmodule

// File: tb/tb_fifo_serializer128.sv
// tb_fifo_serializer128: vector table plus beat scoreboard for fifo_serializer128
module tb_fifo_serializer128;
  logic         CLK, RST;
  logic [127:0] first;
  logic         frdy, drdy, ordy;
  logic         deq_ena, enq_ena;
  logic [31:0]  enq_v;
`ifdef SERIALIZER_LAST_EN
  logic         enq_last;
`endif
  int checks = 0, errors = 0;

  fifo_serializer128 dut (
    .CLK(CLK), .RST(RST),
    .in_first(first), .in_first__RDY(frdy), .in_deq__RDY(drdy),
    .in_deq__ENA(deq_ena), .out_enq_v(enq_v), .out_enq__RDY(ordy),
    .out_enq__ENA(enq_ena)
`ifdef SERIALIZER_LAST_EN
    , .out_enq_last(enq_last)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [127:0] MA = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] MB = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;
  localparam logic [127:0] MC = 128'h0c0c0c03_0c0c0c02_0c0c0c01_0c0c0c00;
  localparam logic [127:0] MD = 128'h0d0d0d03_0d0d0d02_0d0d0d01_0d0d0d00;
  localparam logic [127:0] ME = 128'h0e0e0e03_0e0e0e02_0e0e0e01_0e0e0e00;
  localparam logic [127:0] MF = 128'h0f0f0f03_0f0f0f02_0f0f0f01_0f0f0f00;

  typedef struct {
    logic [127:0] first;
    logic         frdy, drdy, ordy;
    logic         exp_deq, exp_enq;
    logic [31:0]  exp_v;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } beat_t;

  beat_t sb[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (enq_ena) begin
        if (sb.size() == 0) check("unexpected_beat", {96'd0, enq_v}, 128'hx);
        else begin
          beat_t b;
          b = sb.pop_front();
          check("sb_beat", {96'd0, enq_v}, {96'd0, b.w});
`ifdef SERIALIZER_LAST_EN
          check("sb_last", {127'd0, enq_last}, {127'd0, b.last});
`endif
        end
      end
`ifdef SERIALIZER_LAST_EN
      else check("last_idle", {127'd0, enq_last & !busy_hint()}, 128'd0);
`endif
      if (deq_ena)
        for (int i = 0; i < 4; i++) sb.push_back('{first[32*i +: 32], i == 3});
    end
  end

`ifdef SERIALIZER_LAST_EN
  function automatic logic busy_hint();
    return !ordy;
  endfunction
`endif

  vec_t vt[15];

  initial begin
    vt[0]  = '{MA, 1, 1, 1, 1, 0, 32'h0};
    vt[1]  = '{MA, 0, 1, 1, 0, 1, 32'h11111111};
    vt[2]  = '{MB, 1, 1, 0, 0, 0, 32'h22222222};
    vt[3]  = '{MB, 1, 1, 0, 0, 0, 32'h22222222};
    vt[4]  = '{MB, 1, 1, 0, 0, 0, 32'h22222222};
    vt[5]  = '{MB, 0, 1, 1, 0, 1, 32'h22222222};
    vt[6]  = '{MB, 0, 1, 1, 0, 1, 32'h33333333};
    vt[7]  = '{MB, 1, 1, 1, 1, 1, 32'h44444444};
    vt[8]  = '{MB, 0, 1, 1, 0, 1, 32'haaaaaaaa};
    vt[9]  = '{MB, 0, 1, 1, 0, 1, 32'hbbbbbbbb};
    vt[10] = '{MB, 0, 1, 1, 0, 1, 32'hcccccccc};
    vt[11] = '{MB, 0, 1, 1, 0, 1, 32'hdddddddd};
    vt[12] = '{MB, 0, 1, 1, 0, 0, 32'haaaaaaaa};
    vt[13] = '{MB, 1, 0, 1, 0, 0, 32'haaaaaaaa};
    vt[14] = '{MB, 0, 1, 1, 0, 0, 32'haaaaaaaa};

    RST = 1'b1; first = '0; frdy = 0; drdy = 0; ordy = 0;
    step(); step();
    RST = 1'b0; ordy = 1;
    @(negedge CLK);
    check("rst_deq", {127'd0, deq_ena}, 128'd0);
    check("rst_enq", {127'd0, enq_ena}, 128'd0);
    check("rst_v", {96'd0, enq_v}, 128'd0);

    for (int i = 0; i < 15; i++) begin
      step();
      first = vt[i].first; frdy = vt[i].frdy; drdy = vt[i].drdy; ordy = vt[i].ordy;
      @(negedge CLK);
      check($sformatf("vec%0d_deq", i), {127'd0, deq_ena}, {127'd0, vt[i].exp_deq});
      check($sformatf("vec%0d_enq", i), {127'd0, enq_ena}, {127'd0, vt[i].exp_enq});
      check($sformatf("vec%0d_v", i), {96'd0, enq_v}, {96'd0, vt[i].exp_v});
    end

    step();
    first = MC; frdy = 1; drdy = 1; ordy = 1;
    @(negedge CLK);
    check("b2b_deq0", {127'd0, deq_ena}, 128'd1);
    for (int i = 1; i <= 9; i++) begin
      step();
      first = MD; frdy = (i <= 4);
      @(negedge CLK);
      check($sformatf("b2b_enq%0d", i), {127'd0, enq_ena}, {127'd0, i <= 8});
      check($sformatf("b2b_deq%0d", i), {127'd0, deq_ena}, {127'd0, i == 4});
    end
    check("b2b_drained", 128'(sb.size()), 128'd0);

    for (int i = 0; i < 20; i++) begin
      step();
      frdy = 0; drdy = 1; ordy = 1;
      @(negedge CLK);
      check("empty_quiet", {126'd0, deq_ena, enq_ena}, 128'd0);
    end

    step();
    first = ME; frdy = 1; drdy = 1; ordy = 1;
    @(negedge CLK);
    check("rm_load", {127'd0, deq_ena}, 128'd1);
    step(); frdy = 0;
    @(negedge CLK);
    check("rm_beat0", {96'd0, enq_v}, {96'd0, 32'h0e0e0e00});
    step();
    @(negedge CLK);
    check("rm_beat1", {96'd0, enq_v}, {96'd0, 32'h0e0e0e01});
    step();
    RST = 1; frdy = 1; drdy = 1; ordy = 0;
    sb.delete();
    @(negedge CLK);
    check("rm_deq_in_rst", {127'd0, deq_ena}, 128'd0);
    step();
    RST = 0; frdy = 0; ordy = 1;
    @(negedge CLK);
    check("rm_enq_after", {127'd0, enq_ena}, 128'd0);
    check("rm_v_after", {96'd0, enq_v}, 128'd0);
    step();
    first = MF; frdy = 1;
    @(negedge CLK);
    check("rm_reload", {127'd0, deq_ena}, 128'd1);
    step(); frdy = 0;
    @(negedge CLK);
    check("rm_restart_enq", {127'd0, enq_ena}, 128'd1);
    check("rm_restart_v", {96'd0, enq_v}, {96'd0, 32'h0f0f0f00});
    repeat (4) step();
    @(negedge CLK);
    check("final_drained", 128'(sb.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
